// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter.
//   USB_BYTE_W   : default word width (one USB byte)
//   piso_state_e : transmitter FSM states
package piso_pkg;

  localparam int unsigned USB_BYTE_W = 8;

  typedef enum logic {
    PISO_IDLE  = 1'b0,
    PISO_SHIFT = 1'b1
  } piso_state_e;

endpackage

// File: rtl/piso_if.sv
// Handshake bundle between the packet assembler, the PISO and the line encoder.
//   p_data_in / p_data_in_val / p_data_in_rdy : parallel word valid/ready handshake
//   piso_cancel                               : synchronous abort request
//   s_data_out_rdy                            : bit strobe from the line encoder
//   s_data_out / s_data_out_val               : current serial bit and its qualifier
//   s_word_done                               : last bit of a word consumed
// master = word/strobe source side, slave = the PISO itself.
interface piso_if
  import piso_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = USB_BYTE_W
);

  logic [DATA_WIDTH-1:0] p_data_in;
  logic                  p_data_in_val;
  logic                  p_data_in_rdy;
  logic                  piso_cancel;
  logic                  s_data_out_rdy;
  logic                  s_data_out;
  logic                  s_data_out_val;
  logic                  s_word_done;

  modport master (
    output p_data_in, p_data_in_val, piso_cancel, s_data_out_rdy,
    input  p_data_in_rdy, s_data_out, s_data_out_val, s_word_done
  );

  modport slave (
    input  p_data_in, p_data_in_val, piso_cancel, s_data_out_rdy,
    output p_data_in_rdy, s_data_out, s_data_out_val, s_word_done
  );

endinterface

// File: rtl/piso_buf2.sv
// Two-entry ping-pong word buffer feeding the PISO shifter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous flush (pointers and count to zero)
//   push/wdata : write a word (caller guarantees not full)
//   pop/rdata  : head word is always visible on rdata; pop advances it
//   count_nxt  : occupancy after the current edge (used for registered ready)
//   full/empty : occupancy flags for the current cycle
module piso_buf2
  import piso_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = USB_BYTE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            count_nxt,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      cnt_d = cnt_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rdata     = mem_q[rd_ptr_q];
  assign count_nxt = cnt_d;
  assign full      = (cnt_q == 2'd2);
  assign empty     = (cnt_q == 2'd0);

endmodule

// File: rtl/piso.sv
// Parallel-in serial-out transmitter: buffers up to two words and shifts them
// out LSB-first, one bit per s_data_out_rdy strobe, with no gap between words.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : piso_if slave port (word handshake, cancel, serial output)
module piso
  import piso_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = USB_BYTE_W
) (
  input  logic   clk,
  input  logic   rst_n,
  piso_if.slave  bus
);

  localparam int unsigned          CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  piso_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  s_out_q, s_out_d;
  logic                  s_val_q, s_val_d;
  logic                  rdy_q, rdy_d;

  logic                  push, pop, word_done;
  logic [DATA_WIDTH-1:0] buf_rdata;
  logic [1:0]            buf_cnt_nxt;
  logic                  buf_full, buf_empty;

  piso_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (bus.piso_cancel),
    .push      (push),
    .wdata     (bus.p_data_in),
    .pop       (pop),
    .rdata     (buf_rdata),
    .count_nxt (buf_cnt_nxt),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  assign push = bus.p_data_in_val && rdy_q && !bus.piso_cancel && !buf_full;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    pop       = 1'b0;
    word_done = 1'b0;
    if (bus.piso_cancel) begin
      state_d   = PISO_IDLE;
      shift_d   = '0;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        PISO_IDLE: begin
          if (!buf_empty) begin
            pop       = 1'b1;
            shift_d   = buf_rdata;
            bit_cnt_d = '0;
            state_d   = PISO_SHIFT;
          end
        end
        PISO_SHIFT: begin
          if (bus.s_data_out_rdy) begin
            if (bit_cnt_q == LAST_BIT) begin
              word_done = 1'b1;
              bit_cnt_d = '0;
              // Reload on the same edge so the next word follows without a gap.
              if (!buf_empty) begin
                pop     = 1'b1;
                shift_d = buf_rdata;
              end else begin
                shift_d = '0;
                state_d = PISO_IDLE;
              end
            end else begin
              shift_d   = shift_q >> 1;
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = PISO_IDLE;
      endcase
    end
  end

  // Output registers are loaded with what the shifter will present next.
  always_comb begin
    s_val_d = (state_d == PISO_SHIFT);
    s_out_d = s_val_d && shift_d[0];
    rdy_d   = !bus.piso_cancel && (buf_cnt_nxt < 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PISO_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      s_out_q   <= 1'b0;
      s_val_q   <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      s_out_q   <= s_out_d;
      s_val_q   <= s_val_d;
      rdy_q     <= rdy_d;
    end
  end

  assign bus.p_data_in_rdy  = rdy_q;
  assign bus.s_data_out     = s_out_q;
  assign bus.s_data_out_val = s_val_q;
  assign bus.s_word_done    = word_done;

endmodule
